// File: rtl/window_gen_3x3_rgb888.sv
// -----------------------------------------------------------------------------
// window_gen_3x3_rgb888
//
// Front end of the 3x3 RGB888 convolution unit. It takes a raster-scan pixel
// stream, keeps the two previous lines in line buffers and presents one fully
// interior 3x3 window (p1 top-left .. p9 bottom-right, row-major) at a time,
// together with a one-enabled-cycle start pulse. The window is held and the
// pixel source is stalled until the convolution unit reports done. Border
// positions (row < 2 or col < 2) do not produce a window and stream at one
// pixel per enabled cycle.
//
// Ports:
//   iClk            clock
//   iRst            synchronous active-high reset (wins over i_Clk_en)
//   i_Clk_en        clock enable; every state/data update is gated by it
//   i_pixel         {R,G,B} input pixel
//   i_pixel_valid   pixel present
//   i_sof           marks i_pixel as frame pixel (0,0)
//   o_ready         pixel accepted when i_pixel_valid & o_ready & i_Clk_en
//   o_p1..o_p9      current 3x3 window
//   o_win_valid     start pulse to the convolution unit
//   o_win_x/o_win_y window centre column/row
//   i_conv_done     convolution result valid; releases the stall
//   o_frame_done    pulse after the last pixel of a frame is accepted
//   o_overrun       sticky source-violation flag
//
// Build option:
//   WINGEN_OVERRUN_CHECK_EN  when defined, o_overrun flags a start-of-frame
//                            presented during a stall or before the previous
//                            frame completed. When undefined, o_overrun is 0
//                            and the detection logic is not built.
// -----------------------------------------------------------------------------
module window_gen_3x3_rgb888 #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int X_W        = 9,
    parameter int Y_W        = 8
) (
    input  logic           iClk,
    input  logic           iRst,
    input  logic           i_Clk_en,
    input  logic [23:0]    i_pixel,
    input  logic           i_pixel_valid,
    input  logic           i_sof,
    output logic           o_ready,
    output logic [23:0]    o_p1,
    output logic [23:0]    o_p2,
    output logic [23:0]    o_p3,
    output logic [23:0]    o_p4,
    output logic [23:0]    o_p5,
    output logic [23:0]    o_p6,
    output logic [23:0]    o_p7,
    output logic [23:0]    o_p8,
    output logic [23:0]    o_p9,
    output logic           o_win_valid,
    output logic [X_W-1:0] o_win_x,
    output logic [Y_W-1:0] o_win_y,
    input  logic           i_conv_done,
    output logic           o_frame_done,
    output logic           o_overrun
);

    // Line-buffer address width; X_W may be wider than the RAM depth needs.
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [X_W-1:0] COL_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [X_W-1:0] col;
    logic [Y_W-1:0] row;

    // LB0 holds row r-2, LB1 holds row r-1 (not reset)
    logic [23:0] lb0 [IMG_WIDTH];
    logic [23:0] lb1 [IMG_WIDTH];

    logic [X_W-1:0] cur_col;
    logic [Y_W-1:0] cur_row;
    logic [AW-1:0]  lb_addr;
    logic [23:0]    lb0_rd;
    logic [23:0]    lb1_rd;
    logic           accept;
    logic           col_last;
    logic           row_last;
    logic           interior;

    // i_sof relocates the incoming pixel to (0,0) whatever the counters hold
    assign cur_col  = i_sof ? '0 : col;
    assign cur_row  = i_sof ? '0 : row;
    assign lb_addr  = cur_col[AW-1:0];
    assign lb0_rd   = lb0[lb_addr];
    assign lb1_rd   = lb1[lb_addr];

    assign accept   = i_Clk_en & i_pixel_valid & o_ready;
    assign col_last = (cur_col == COL_LAST);
    assign row_last = (cur_row == ROW_LAST);
    assign interior = (cur_row >= Y_W'(2)) && (cur_col >= X_W'(2));

    // -------------------------------------------------------------------------
    // Control FSM: next state and decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        o_ready     = 1'b0;
        o_win_valid = 1'b0;
        case (state)
            ST_RUN: begin
                o_ready = 1'b1;
                // the state register only loads on i_Clk_en, so valid plus
                // interior is the same as an interior accept here
                if (i_pixel_valid && interior) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_win_valid = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_conv_done) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters, window registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= ST_RUN;
            col          <= '0;
            row          <= '0;
            o_p1         <= '0;
            o_p2         <= '0;
            o_p3         <= '0;
            o_p4         <= '0;
            o_p5         <= '0;
            o_p6         <= '0;
            o_p7         <= '0;
            o_p8         <= '0;
            o_p9         <= '0;
            o_win_x      <= '0;
            o_win_y      <= '0;
            o_frame_done <= 1'b0;
        end else if (i_Clk_en) begin
            state        <= state_nxt;
            o_frame_done <= accept && col_last && row_last;

            if (accept) begin
                // window slides left; new right column comes from the
                // line buffers (read before this cycle's write) and the input
                o_p1 <= o_p2;
                o_p2 <= o_p3;
                o_p3 <= lb0_rd;
                o_p4 <= o_p5;
                o_p5 <= o_p6;
                o_p6 <= lb1_rd;
                o_p7 <= o_p8;
                o_p8 <= o_p9;
                o_p9 <= i_pixel;

                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                    end else begin
                        row <= cur_row + Y_W'(1);
                    end
                end else begin
                    col <= cur_col + X_W'(1);
                    row <= cur_row;
                end

                if (interior) begin
                    o_win_x <= cur_col - X_W'(1);
                    o_win_y <= cur_row - Y_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers: LB1 column moves down into LB0, new pixel enters LB1
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRst && accept) begin
            lb0[lb_addr] <= lb1_rd;
            lb1[lb_addr] <= i_pixel;
        end
    end

    // -------------------------------------------------------------------------
    // Source-violation detection
    // -------------------------------------------------------------------------
`ifdef WINGEN_OVERRUN_CHECK_EN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            o_overrun <= 1'b0;
        end else if (i_Clk_en && i_pixel_valid && i_sof &&
                     (!o_ready || (col != '0) || (row != '0))) begin
            o_overrun <= 1'b1;
        end
    end
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_window_gen_3x3_rgb888.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3_rgb888
//
// Directed bench for window_gen_3x3_rgb888 on a 5x4 frame. Pixel value at
// (r,c) is {r,c,AA} plus a per-frame offset, so every expected window tap is
// computed from its coordinates. A small convolution stand-in answers each
// start pulse with done five enabled cycles later (or holds it off on demand).
// -----------------------------------------------------------------------------
module tb_window_gen_3x3_rgb888;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int XW   = 3;
    localparam int YW   = 2;
    localparam int MAXW = 128;

`ifdef WINGEN_OVERRUN_CHECK_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          iRst          = 1'b1;
    logic          i_Clk_en      = 1'b1;
    logic [23:0]   i_pixel       = '0;
    logic          i_pixel_valid = 1'b0;
    logic          i_sof         = 1'b0;
    logic          i_conv_done   = 1'b0;
    logic          o_ready;
    logic [23:0]   o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9;
    logic          o_win_valid;
    logic [XW-1:0] o_win_x;
    logic [YW-1:0] o_win_y;
    logic          o_frame_done;
    logic          o_overrun;

    window_gen_3x3_rgb888 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .X_W       (XW),
        .Y_W       (YW)
    ) dut (
        .iClk         (clk),
        .iRst         (iRst),
        .i_Clk_en     (i_Clk_en),
        .i_pixel      (i_pixel),
        .i_pixel_valid(i_pixel_valid),
        .i_sof        (i_sof),
        .o_ready      (o_ready),
        .o_p1         (o_p1),
        .o_p2         (o_p2),
        .o_p3         (o_p3),
        .o_p4         (o_p4),
        .o_p5         (o_p5),
        .o_p6         (o_p6),
        .o_p7         (o_p7),
        .o_p8         (o_p8),
        .o_p9         (o_p9),
        .o_win_valid  (o_win_valid),
        .o_win_x      (o_win_x),
        .o_win_y      (o_win_y),
        .i_conv_done  (i_conv_done),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    int win_cnt  = 0;
    int fd_cnt   = 0;
    int conv_cnt = 0;
    bit conv_hold = 1'b0;
    bit en_slow   = 1'b0;
    int en_ph     = 0;

    int          rec_x [MAXW];
    int          rec_y [MAXW];
    logic [23:0] rec_p [MAXW][9];

    // clock enable: always on, or one enabled cycle in three
    always @(posedge clk) begin
        #1;
        if (en_slow) begin
            en_ph    = (en_ph == 2) ? 0 : en_ph + 1;
            i_Clk_en = (en_ph == 0);
        end else begin
            i_Clk_en = 1'b1;
        end
    end

    // convolution stand-in: done on the 5th enabled cycle after the pulse
    always @(negedge clk) begin
        i_conv_done = 1'b0;
        if (iRst) begin
            conv_cnt = 0;
        end else if (i_Clk_en) begin
            if (o_win_valid) begin
                conv_cnt = 5;
            end else if (conv_cnt > 1 || (conv_cnt == 1 && !conv_hold)) begin
                conv_cnt = conv_cnt - 1;
                if (conv_cnt == 0) i_conv_done = 1'b1;
            end
        end
    end

    // window / frame-done recorder, one entry per enabled pulse cycle
    always @(negedge clk) begin
        if (!iRst && i_Clk_en) begin
            if (o_win_valid) begin
                if (win_cnt < MAXW) begin
                    rec_x[win_cnt]    = int'(o_win_x);
                    rec_y[win_cnt]    = int'(o_win_y);
                    rec_p[win_cnt][0] = o_p1;
                    rec_p[win_cnt][1] = o_p2;
                    rec_p[win_cnt][2] = o_p3;
                    rec_p[win_cnt][3] = o_p4;
                    rec_p[win_cnt][4] = o_p5;
                    rec_p[win_cnt][5] = o_p6;
                    rec_p[win_cnt][6] = o_p7;
                    rec_p[win_cnt][7] = o_p8;
                    rec_p[win_cnt][8] = o_p9;
                end
                win_cnt = win_cnt + 1;
            end
            if (o_frame_done) fd_cnt = fd_cnt + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pix(input int r, input int c, input int off);
        return {8'(r), 8'(c), 8'hAA} + 24'(off);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_win_valid", 32'(o_win_valid), 0);
        chk("rst_p1", 32'(o_p1), 0);
        chk("rst_p2", 32'(o_p2), 0);
        chk("rst_p3", 32'(o_p3), 0);
        chk("rst_p4", 32'(o_p4), 0);
        chk("rst_p5", 32'(o_p5), 0);
        chk("rst_p6", 32'(o_p6), 0);
        chk("rst_p7", 32'(o_p7), 0);
        chk("rst_p8", 32'(o_p8), 0);
        chk("rst_p9", 32'(o_p9), 0);
        chk("rst_win_x", 32'(o_win_x), 0);
        chk("rst_win_y", 32'(o_win_y), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_overrun", 32'(o_overrun), 0);
    endtask

    // all tasks below enter and leave one time unit after a rising edge
    task automatic do_reset();
        iRst          = 1'b1;
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        iRst = 1'b0;
        chk_reset();
    endtask

    task automatic send_pixel(input logic [23:0] px, input bit sof);
        int n  = 0;
        bit ok = 1'b0;
        // a well-behaved source only starts a frame while the block is ready
        if (sof) begin
            while (!ok && n < 300) begin
                @(negedge clk);
                #1;
                if (o_ready) ok = 1'b1;
                @(posedge clk);
                #1;
                n = n + 1;
            end
            ok = 1'b0;
            n  = 0;
        end
        i_pixel       = px;
        i_sof         = sof;
        i_pixel_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            #1;
            if (o_ready && i_Clk_en) ok = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 1);
    endtask

    task automatic send_frame(input int off, input bit sof, input int npix);
        int n   = 0;
        int fd0 = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n < npix) begin
                    if (npix == W * H && n == W * H - 1)
                        chk("frame_done_early", 32'(fd_cnt - fd0), 0);
                    send_pixel(pix(r, c, off), sof && (n == 0));
                    if (n == 0) fd0 = fd_cnt;
                end
                n = n + 1;
            end
        end
    endtask

    task automatic wait_idle();
        int n  = 0;
        bit ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk);
            #1;
            if (o_ready && !o_win_valid && conv_cnt == 0) ok = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("idle_timeout", 32'(ok), 1);
    endtask

    // six windows in raster order of their centres
    task automatic check_frame(input int base, input int off);
        for (int k = 0; k < 6; k++) begin
            int x = 1 + k % 3;
            int y = 1 + k / 3;
            chk($sformatf("win%0d_x", base + k), 32'(rec_x[base + k]), 32'(x));
            chk($sformatf("win%0d_y", base + k), 32'(rec_y[base + k]), 32'(y));
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("win%0d_p%0d", base + k, i * 3 + j + 1),
                        32'(rec_p[base + k][i * 3 + j]),
                        32'(pix(y - 1 + i, x - 1 + j, off)));
                end
            end
        end
    endtask

    initial begin
        int base;
        int fdb;
        int n;
        bit ok;

        // 1: reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        iRst = 1'b0;
        chk_reset();

        // 2: full frame at full rate
        base = win_cnt;
        fdb  = fd_cnt;
        send_frame(0, 1'b1, W * H);
        wait_idle();
        chk("t2_win_count", 32'(win_cnt - base), 6);
        check_frame(base, 0);
        chk("t2_first_p1", 32'(rec_p[base][0]), 32'(24'h0000AA));
        chk("t2_first_p5", 32'(rec_p[base][4]), 32'(24'h0101AA));
        chk("t2_first_p9", 32'(rec_p[base][8]), 32'(24'h0202AA));
        chk("t2_frame_done", 32'(fd_cnt - fdb), 1);

        // 3: convolution holds done low, next pixel waiting
        do_reset();
        conv_hold = 1'b1;
        base      = win_cnt;
        send_frame(0, 1'b1, 13);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            #1;
            if (win_cnt == base + 1) ok = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("t3_window_seen", 32'(ok), 1);
        i_pixel       = pix(2, 3, 0);
        i_pixel_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t3_ready_low", 32'(o_ready), 0);
            chk("t3_no_pulse", 32'(o_win_valid), 0);
            chk("t3_p1_hold", 32'(o_p1), 32'(pix(0, 0, 0)));
            chk("t3_p5_hold", 32'(o_p5), 32'(pix(1, 1, 0)));
            chk("t3_p9_hold", 32'(o_p9), 32'(pix(2, 2, 0)));
        end
        chk("t3_win_count", 32'(win_cnt - base), 1);
        conv_hold = 1'b0;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            #1;
            if (i_conv_done) ok = 1'b1;
            n = n + 1;
        end
        chk("t3_done_seen", 32'(ok), 1);
        @(posedge clk);
        #1;
        chk("t3_ready_after_done", 32'(o_ready), 1);
        i_pixel_valid = 1'b0;

        // 4: same frame with clock enable one cycle in three
        do_reset();
        en_slow = 1'b1;
        base    = win_cnt;
        fdb     = fd_cnt;
        send_frame(0, 1'b1, W * H);
        wait_idle();
        en_slow = 1'b0;
        chk("t4_win_count", 32'(win_cnt - base), 6);
        check_frame(base, 0);
        chk("t4_frame_done", 32'(fd_cnt - fdb), 1);

        // 5: two frames back to back, second one offset by +1
        do_reset();
        base = win_cnt;
        fdb  = fd_cnt;
        send_frame(0, 1'b1, W * H);
        send_frame(1, 1'b1, W * H);
        wait_idle();
        chk("t5_win_count", 32'(win_cnt - base), 12);
        check_frame(base, 0);
        check_frame(base + 6, 1);
        chk("t5_second_p5", 32'(rec_p[base + 6][4]), 32'(24'h0101AB));
        chk("t5_frame_done", 32'(fd_cnt - fdb), 2);
        chk("t5_overrun", 32'(o_overrun), 0);

        // 6: reset mid-frame, fresh frame, then a misplaced start of frame
        do_reset();
        send_frame(0, 1'b1, 9);
        do_reset();
        base = win_cnt;
        send_frame(2, 1'b1, W * H);
        wait_idle();
        chk("t6_win_count", 32'(win_cnt - base), 6);
        check_frame(base, 2);
        chk("t6_overrun_clean", 32'(o_overrun), 0);
        send_pixel(pix(0, 0, 0), 1'b1);
        send_pixel(pix(0, 1, 0), 1'b0);
        send_pixel(pix(0, 2, 0), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_overrun_set", 32'(o_overrun), 32'(OVR_EXP));
        send_pixel(pix(0, 1, 0), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_overrun_sticky", 32'(o_overrun), 32'(OVR_EXP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3_rgb888.md
Name: window_gen_3x3_rgb888

Overview:
Upstream stage of the 3x3 RGB888 convolution unit. Accepts a raster-scan RGB888 pixel stream and buffers the two previous lines. Presents a stable 3x3 window (p1..p9) plus a 1-cycle start pulse to the convolution unit. Holds that window and stalls the pixel source until the convolution reports its result done. Only fully-interior windows are produced (valid-only, no padding).

Parameters:
IMG_WIDTH, 320, pixels per line (>=3)
IMG_HEIGHT, 240, lines per frame (>=3)
X_W, 9, column counter / o_win_x width (2^X_W >= IMG_WIDTH)
Y_W, 8, row counter / o_win_y width (2^Y_W >= IMG_HEIGHT)

Ports:
iClk  in  1  clock
iRst  in  1  reset; synchronous, active-high
i_Clk_en  in  1  clock enable; all state/data updates only when 1
i_pixel  in  24  {R,G,B} input pixel
i_pixel_valid  in  1  pixel present
i_sof  in  1  qualifies i_pixel as frame pixel (0,0)
o_ready  out  1  pixel accepted when i_pixel_valid & o_ready & i_Clk_en
o_p1..o_p9  out  24 each  window, p1 top-left .. p9 bottom-right, row-major
o_win_valid  out  1  start pulse to conv i_enable
o_win_x  out  X_W  window centre column
o_win_y  out  Y_W  window centre row
i_conv_done  in  1  conv o_result_valid
o_frame_done  out  1  pulse after last pixel of frame accepted
o_overrun  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (iRst=1 at edge, regardless of i_Clk_en): state ST_RUN; col=row=0; o_p1..o_p9=0; o_win_valid=0; o_win_x=o_win_y=0; o_frame_done=0; o_overrun=0. o_ready=1 after reset. Line-buffer RAM is not reset. Mid-frame reset discards the partial frame and any pending window.
- Storage: two line buffers, IMG_WIDTH x 24 each. LB0 holds row r-2, LB1 holds row r-1. Read-before-write at the same address.
- Accept at (r,c):
  - Window shifts left one column.
  - New right column: p3 = LB0[c], p6 = LB1[c], p9 = i_pixel.
  - LB0[c] <= LB1[c]; LB1[c] <= i_pixel.
  - col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), row and col wrap to 0,0 and o_frame_done is high for the next clk_en cycle.
- i_sof on an accepted pixel forces that pixel to (0,0); counters continue from (0,1).
- FSM (transitions only when i_Clk_en=1):
  - ST_RUN: o_ready=1. Accepting a pixel with r>=2 and c>=2 goes to ST_ISSUE and latches o_win_x=c-1, o_win_y=r-1. Otherwise stays in ST_RUN.
  - ST_ISSUE: o_ready=0, o_win_valid=1 for exactly one clk_en cycle, then goes to ST_WAIT.
  - ST_WAIT: o_ready=0. Goes to ST_RUN when i_conv_done=1.
- o_p1..o_p9 are registered and change only on an accept. They are therefore stable from the ISSUE cycle until i_conv_done, which covers the conv CALC_R/G/B states.
- i_conv_done in ST_RUN or ST_ISSUE: ignored.
- i_Clk_en=0: everything holds, including o_win_valid and o_frame_done levels. This guarantees each pulse spans exactly one enabled cycle.
- Throughput: at most one window per 7 clk_en cycles (ISSUE + conv 5 states + return to RUN). Border pixels (r<2 or c<2) stream at 1 per clk_en.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).

Optional Feature:
WINGEN_OVERRUN_CHECK_EN
- Defined: o_overrun sets and stays 1 (until iRst) when i_pixel_valid=1 and o_ready=0 with i_Clk_en=1 while i_sof=1. A new frame started mid-stall is the source violation.
- Also defined: o_overrun sets when i_sof arrives with col!=0 or row!=0 (short frame).
- Not defined: o_overrun is tied to 0 and the detection logic is absent.

Test Plan:
1. Reset: IMG_WIDTH=5, IMG_HEIGHT=4, iRst held 2 cycles -> o_ready=1, o_win_valid=0, all o_p=0, o_overrun=0.
2. Stream the full 5x4 frame, pixel={8'(row),8'(col),8'hAA}, conv model returning done 5 cycles after the pulse -> exactly 6 windows in order (x,y)=(1,1),(2,1),(3,1),(1,2),(2,2),(3,2). First window: p1={0,0,AA}, p5={1,1,AA}, p9={2,2,AA}. o_frame_done pulses once after pixel (3,4).
3. Hold i_conv_done low 20 cycles after a window -> o_ready=0 throughout, o_p* unchanged, no second o_win_valid. Raise done -> o_ready=1 next cycle.
4. i_Clk_en toggling 1-of-3 over the test-2 stimulus -> identical window sequence. o_win_valid is high for exactly one enabled cycle each time.
5. Second frame back-to-back with i_sof on its first pixel, data +1 -> first window p5={1,1,AA}+1-valued. No stale first-frame pixels appear in any window.
6. Mid-frame iRst after 9 pixels, then a fresh frame with i_sof (macro defined) -> reset values restored, then 6 correct windows. o_overrun stays 0. Asserting i_sof at col=2 -> o_overrun=1 and stays 1.
